dmem_lsu: RTL

//  Load/store unit: initiator side of the data-memory port. Accepts one byte/half/word

---
 rtl/dmem_lsu.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-addressed data memory.
// Sub-word stores are done as read-modify-write.
module dmem_lsu #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    WRITE,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [1:0]        off;
    logic [ADDR_W-1:0] idx;
  } req_t;

  state_t            state;
  state_t            state_nxt;
  req_t              rq;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              bad;
  logic              sub_st;
  logic [ADDR_W-1:0] idx_in;

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  size,
    input logic        uns,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {off, 3'b000});
    h = 16'(w >> {off[1], 4'b0000});
    unique case (size)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace one lane of the fetched word with right-aligned store data.
  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic [1:0]  size,
    input logic [1:0]  off
  );
    logic [31:0] m;
    logic [31:0] s;
    if (size == 2'b00) begin
      m = 32'h0000_00ff << {off, 3'b000};
      s = {24'b0, d[7:0]} << {off, 3'b000};
    end else begin
      m = 32'h0000_ffff << {off[1], 4'b0000};
      s = {16'b0, d[15:0]} << {off[1], 4'b0000};
    end
    return (w & ~m) | (s & m);
  endfunction

  assign idx_in    = req_addr >> 2;
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign sub_st    = req_we && (req_size != 2'b10);

  always_comb begin
    bad = 1'b0;
    unique case (req_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      default: bad = 1'b1;
    endcase
    if (idx_in >= DEPTH_W) bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad)         state_nxt = RESP;
          else if (req_we && !sub_st)
                           state_nxt = WRITE;
          else             state_nxt = READ;
        end
      end
      READ: begin
        mem_en    = 1'b1;
        mem_addr  = rq.idx;
        state_nxt = CAPT;
      end
      CAPT: begin
        state_nxt = rq.we ? WRITE : RESP;
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = rq.idx;
        mem_wdata = word_q;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq      <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        rq.we   <= req_we;
        rq.size <= req_size;
        rq.uns  <= req_unsigned;
        rq.off  <= req_addr[1:0];
        rq.idx  <= idx_in;
        word_q  <= req_wdata;
        rdata_q <= '0;
        err_q   <= bad;
      end
      if (state == CAPT) begin
        if (rq.we)
          word_q <= merge(mem_rdata, word_q, rq.size, rq.off);
        else
          rdata_q <= load_ext(mem_rdata, rq.size, rq.uns, rq.off);
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
